// File: rtl/delay_pkg.sv
// Shared types and default widths for the delay-line controller.
// Optional build macro used by delay_ctrl: DELAY_CTRL_STATS_EN (adds run_cnt).
package delay_pkg;

    // Controller state encoding; 3 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    localparam int DEF_A_WIDTH = 9;
    localparam int DEF_D_WIDTH = 8;

endpackage

// File: rtl/delay_ctrl.sv
// Delay-line controller: sequences the address counter and dual-port RAM of an
// audio delay. FILL pre-loads 'offset' samples (write only), RUN writes and
// reads every sample, IDLE does nothing.
// Build macro DELAY_CTRL_STATS_EN adds a 16-bit saturating count of RUN reads.
module delay_ctrl
    import delay_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic               start,
    input  logic               stop,
    input  logic [D_WIDTH-1:0] offset_in,
    input  logic               offset_vld,
    output logic               offset_rdy,
    output logic [D_WIDTH-1:0] offset,
    output logic               en,
    output logic               write_en,
    output logic               read_en,
    output logic               dout_vld,
    output logic [1:0]         state
`ifdef DELAY_CTRL_STATS_EN
    ,
    output logic [15:0]        run_cnt
`endif
);

    state_t             r_state;
    logic [D_WIDTH-1:0] r_offset;
    logic [D_WIDTH:0]   r_fill_cnt;
    logic               r_dout_vld;

    state_t             w_state_next;
    logic [D_WIDTH-1:0] w_offset_next;
    logic [D_WIDTH:0]   w_fill_next;
    logic [D_WIDTH:0]   w_fill_inc;
    logic [D_WIDTH-1:0] w_offset_lim;
    logic               w_xfer;
    logic               w_active;

    // A delay longer than the RAM can hold is clamped to the deepest address.
    generate
        if (A_WIDTH >= D_WIDTH) begin : g_offset_fits
            assign w_offset_lim = offset_in;
        end else begin : g_offset_clamp
            localparam logic [D_WIDTH-1:0] MAX_OFFSET = D_WIDTH'({A_WIDTH{1'b1}});
            assign w_offset_lim = (offset_in > MAX_OFFSET) ? MAX_OFFSET : offset_in;
        end
    endgenerate

    // Ready only in IDLE/RUN; withheld while stop or reset would discard the load.
    assign offset_rdy = !rst && !stop && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_xfer     = offset_vld && offset_rdy;

    // Strobes follow the registered state on each sample tick; nothing during reset.
    assign w_active = sample_tick && !rst;
    assign en       = w_active && ((r_state == ST_FILL) || (r_state == ST_RUN));
    assign write_en = en;
    assign read_en  = w_active && (r_state == ST_RUN);

    // Fill counter never wraps.
    assign w_fill_inc = (r_fill_cnt == {(D_WIDTH+1){1'b1}}) ? r_fill_cnt : r_fill_cnt + 1'b1;

    assign offset   = r_offset;
    assign dout_vld = r_dout_vld;
    assign state    = r_state;

    // Next-state, offset and fill-count decisions; stop overrides everything.
    always_comb begin
        w_state_next  = r_state;
        w_offset_next = r_offset;
        w_fill_next   = r_fill_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_offset_next = w_offset_lim;
                end
                if (start) begin
                    w_fill_next  = '0;
                    w_state_next = (w_offset_next != '0) ? ST_FILL : ST_RUN;
                end
            end
            ST_FILL: begin
                // A zero delay reloaded from RUN has nothing to pre-fill.
                if (r_offset == '0) begin
                    w_state_next = ST_RUN;
                end else if (sample_tick) begin
                    w_fill_next = w_fill_inc;
                    if (w_fill_inc == {1'b0, r_offset}) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // The coincident tick is still serviced as RUN with the old offset.
                if (w_xfer) begin
                    w_offset_next = w_offset_lim;
                    w_fill_next   = '0;
                    w_state_next  = ST_FILL;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (stop) begin
            w_state_next  = ST_IDLE;
            w_offset_next = r_offset;
            w_fill_next   = r_fill_cnt;
        end
    end

    // State register plus offset, fill count and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_offset   <= '0;
            r_fill_cnt <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_offset   <= w_offset_next;
            r_fill_cnt <= w_fill_next;
            r_dout_vld <= read_en;
        end
    end

`ifdef DELAY_CTRL_STATS_EN
    logic [15:0] r_run_cnt;

    assign run_cnt = r_run_cnt;

    // Saturating count of RUN reads, restarted whenever a new fill begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt <= '0;
        end else if ((w_state_next == ST_FILL) && (r_state != ST_FILL)) begin
            r_run_cnt <= '0;
        end else if (read_en && (r_run_cnt != 16'hFFFF)) begin
            r_run_cnt <= r_run_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the controller.
module tb_delay_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] offset_in = '0;
    logic       offset_vld = 1'b0;
    logic       offset_rdy;
    logic [7:0] offset;
    logic       en, write_en, read_en, dout_vld;
    logic [1:0] state;
`ifdef DELAY_CTRL_STATS_EN
    logic [15:0] run_cnt;
`endif

    delay_ctrl #(.A_WIDTH(9), .D_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .start       (start),
        .stop        (stop),
        .offset_in   (offset_in),
        .offset_vld  (offset_vld),
        .offset_rdy  (offset_rdy),
        .offset      (offset),
        .en          (en),
        .write_en    (write_en),
        .read_en     (read_en),
        .dout_vld    (dout_vld),
        .state       (state)
`ifdef DELAY_CTRL_STATS_EN
        ,
        .run_cnt     (run_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0 idle, 1 pre-filling, 2 running.
    int m_mode = 0;
    int m_delay = 0;
    int m_written = 0;
    int m_read_prev = 0;
    int m_reads = 0;

    // Observed strobes from the most recent step, for directed checks.
    int obs_en, obs_we, obs_re, obs_state, obs_offset, obs_rdy, obs_dv;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit r, input bit tk, input bit st, input bit sp,
                        input bit vld, input logic [7:0] off);
        int e_busy, e_read, e_rdy, old_mode;
        @(negedge clk);
        rst = r; sample_tick = tk; start = st; stop = sp;
        offset_vld = vld; offset_in = off;
        #1;
        e_busy = (!r && tk && m_mode != 0) ? 1 : 0;
        e_read = (!r && tk && m_mode == 2) ? 1 : 0;
        e_rdy  = (!r && !sp && (m_mode == 0 || m_mode == 2)) ? 1 : 0;
        obs_en = int'(en); obs_we = int'(write_en); obs_re = int'(read_en);
        obs_state = int'(state); obs_offset = int'(offset);
        obs_rdy = int'(offset_rdy); obs_dv = int'(dout_vld);
        chk("en", obs_en, e_busy);
        chk("write_en", obs_we, e_busy);
        chk("read_en", obs_re, e_read);
        chk("offset_rdy", obs_rdy, e_rdy);
        chk("state", obs_state, m_mode);
        chk("offset", obs_offset, m_delay);
        chk("dout_vld", obs_dv, m_read_prev);
`ifdef DELAY_CTRL_STATS_EN
        chk("run_cnt", int'(run_cnt), m_reads);
`endif
        if (r) begin
            m_mode = 0; m_delay = 0; m_written = 0; m_read_prev = 0; m_reads = 0;
        end else begin
            old_mode = m_mode;
            m_read_prev = e_read;
            if (sp) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (vld) m_delay = int'(off);
                if (st) begin
                    m_written = 0;
                    m_mode = (m_delay != 0) ? 1 : 2;
                end
            end else if (m_mode == 1) begin
                if (m_delay == 0) m_mode = 2;
                else if (tk) begin
                    m_written++;
                    if (m_written == m_delay) m_mode = 2;
                end
            end else begin
                if (vld) begin
                    m_delay = int'(off);
                    m_written = 0;
                    m_mode = 1;
                end
            end
            if (m_mode == 1 && old_mode != 1) m_reads = 0;
            else if (e_read == 1 && m_reads < 65535) m_reads++;
        end
        @(posedge clk);
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 0, 0, 8'd0);
    endtask

    initial begin
        // Reset state.
        step(1, 0, 0, 0, 0, 8'd0);
        idle_cycle();
        chk("rst_state", obs_state, 0);
        chk("rst_offset", obs_offset, 0);
        chk("rst_dout_vld", obs_dv, 0);

        // Delay of 3: three write-only ticks, then full RUN strobes.
        step(0, 0, 0, 0, 1, 8'd3);
        step(0, 0, 1, 0, 0, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, 0, 0, 0, 8'd0);
            chk("fill_run_re", obs_re, (k >= 4) ? 1 : 0);
            chk("fill_run_we", obs_we, 1);
            idle_cycle();
            chk("fill_run_dv", obs_dv, (k >= 4) ? 1 : 0);
        end
        chk("fill_run_state", obs_state, 2);

        // Offset reload of 5 coincident with a RUN tick.
        step(0, 1, 0, 0, 1, 8'd5);
        chk("reload_re", obs_re, 1);
        idle_cycle();
        chk("reload_state", obs_state, 1);
        chk("reload_offset", obs_offset, 5);
        chk("reload_rdy", obs_rdy, 0);

        // stop together with start while filling.
        step(0, 1, 1, 1, 0, 8'd0);
        chk("stop_strobe", obs_we, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0, 0, 8'd0);
            chk("stop_idle_en", obs_en, 0);
        end
        chk("stop_state", obs_state, 0);

        // Zero delay goes straight to RUN.
        step(1, 0, 0, 0, 0, 8'd0);
        step(0, 0, 1, 0, 0, 8'd0);
        step(0, 1, 0, 0, 0, 8'd0);
        chk("zero_state", obs_state, 2);
        chk("zero_re", obs_re, 1);

        // Reset mid-RUN on a tick.
        step(1, 1, 0, 0, 0, 8'd0);
        chk("rst_run_en", obs_en, 0);
        idle_cycle();
        chk("rst_run_state", obs_state, 0);
        chk("rst_run_dv", obs_dv, 0);

`ifdef DELAY_CTRL_STATS_EN
        step(0, 0, 1, 0, 0, 8'd0);
        for (int k = 0; k < 70000; k++) step(0, 1, 0, 0, 0, 8'd0);
        idle_cycle();
        chk("run_cnt_sat", int'(run_cnt), 65535);
        step(1, 0, 0, 0, 0, 8'd0);
`endif

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] off;
            off = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 6))
                                              : 8'($urandom_range(0, 255));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 7) == 0), off);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_ctrl.md
DELAY_CTRL -- requirements
Module: delay_ctrl

Interface
REQ-001 SHALL have parameter A_WIDTH, default 9, RAM address width.
REQ-002 SHALL have parameter D_WIDTH, default 8, sample and offset width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port sample_tick  input  1  one-cycle strobe, one per audio sample.
REQ-006 SHALL have port start  input  1  level/pulse request to begin delay operation.
REQ-007 SHALL have port stop  input  1  request to halt and return to IDLE.
REQ-008 SHALL have port offset_in  input  D_WIDTH  requested delay in samples.
REQ-009 SHALL have port offset_vld  input  1  offset_in valid (valid/ready handshake).
REQ-010 SHALL have port offset_rdy  output  1  controller can accept offset_in this cycle.
REQ-011 SHALL have port offset  output  D_WIDTH  registered active delay, drives the address counter.
REQ-012 SHALL have ports en, write_en, read_en  output  1 each  address-counter advance, RAM write strobe, RAM read strobe.
REQ-013 SHALL have port dout_vld  output  1  delayed RAM output valid.
REQ-014 SHALL have port state  output  2  current state encoding.

Function
REQ-015 SHALL implement states IDLE=0, FILL=1, RUN=2; encoding 3 unused and SHALL recover to IDLE next cycle.
REQ-016 Transfer SHALL occur when offset_vld && offset_rdy at a rising edge; offset_rdy SHALL be 1 in IDLE and RUN, 0 in FILL.
REQ-017 Accepted offset_in SHALL load into offset at that edge; in RUN, an accepted transfer SHALL move to FILL and clear fill_cnt.
REQ-018 IDLE: start=1 SHALL move to FILL if offset!=0, directly to RUN if offset==0; fill_cnt cleared.
REQ-019 FILL: on sample_tick, en=1, write_en=1, read_en=0 in the same cycle (combinational from registered state and tick); fill_cnt increments.
REQ-020 FILL SHALL move to RUN at the edge of the tick on which fill_cnt reaches offset (i.e. after exactly offset written samples).
REQ-021 RUN: on sample_tick, en, write_en, read_en SHALL all be 1 in the same cycle.
REQ-022 dout_vld SHALL be registered, asserting exactly one cycle after a RUN cycle with read_en=1, for one cycle.
REQ-023 Outside sample_tick cycles, en, write_en, read_en SHALL be 0; in IDLE they SHALL be 0 regardless of sample_tick.
REQ-024 stop SHALL move any state to IDLE at the next edge and has priority over start, offset transfer and tick-driven transitions; strobes in that cycle remain per current state.
REQ-025 RUN with sample_tick and accepted offset in the same cycle: the tick SHALL be serviced as RUN with the old offset; FILL with new offset follows.
REQ-026 fill_cnt SHALL be D_WIDTH+1 bits, never wraps; offset SHALL be zero-extended to A_WIDTH by the counter.

Reset
REQ-027 On rst: state=IDLE, offset=0, fill_cnt=0, dout_vld=0; en, write_en, read_en SHALL be 0 during the reset cycle; rst mid-FILL or mid-RUN SHALL abort with no further strobes.

Configuration
REQ-028 With macro DELAY_CTRL_STATS_EN defined, SHALL add output run_cnt (16 bits), counting RUN read cycles, saturating at 16'hFFFF, cleared by rst and on entry to FILL.
REQ-029 Without DELAY_CTRL_STATS_EN, run_cnt port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package delay_pkg SHALL hold the state enum typedef and default A_WIDTH/D_WIDTH constants.
REQ-031 No sub-module; the parent instantiates delay_ctrl beside the address counter and dual-port RAM.

Verification
REQ-032 Reset then offset_in=3 transfer, start, 6 ticks -> state FILL for ticks 1-3 (write_en only), RUN ticks 4-6 with read_en, dout_vld one cycle after each.
REQ-033 offset=0, start -> RUN immediately; first tick asserts en, write_en, read_en together.
REQ-034 In RUN, offset_vld with offset_in=5 coincident with tick -> that tick full RUN strobes; next state FILL, offset=5, offset_rdy=0 until RUN.
REQ-035 stop and start asserted together in FILL -> IDLE next cycle; subsequent ticks produce no strobes.
REQ-036 rst asserted mid-RUN with tick -> no strobes, state=0, offset=0, dout_vld=0 next cycle.
REQ-037 With DELAY_CTRL_STATS_EN, 70000 RUN ticks -> run_cnt=16'hFFFF.
